// File: rtl/uart_stream_adapter.sv
// Bridges a UART controller register port to byte streams: polls status, pulls
// RX bytes into a first-word-fall-through FIFO and pushes held TX bytes out.
module uart_stream_adapter #(
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_DIV   = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        rst_n_i,
  output logic                        wb_cyc_o,
  output logic                        wb_we_o,
  output logic [1:0]                  wb_addr_o,
  input  logic [7:0]                  wb_datr_i,
  output logic [7:0]                  wb_datw_o,
  input  logic                        int_i,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;

  typedef enum logic [2:0] {IDLE, ST_RD, ST_CAP, RX_RD, RX_CAP, TX_WR} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_poll;
  logic          w_poll_inc, w_poll_clr, w_tx_done;
  logic          r_held;
  logic [7:0]    r_tx_data;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_full, w_push, w_pop;

  assign w_full     = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_push     = (r_state == RX_CAP);
  assign w_pop      = rx_valid_o & rx_ready_i;
  assign rx_valid_o = (r_level != '0);
  assign rx_data_o  = rx_valid_o ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_level_o = r_level;
  assign tx_ready_o = ~r_held;

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Status decision uses the read data returned in ST_CAP directly; only bits 1:0 matter.
  always_comb begin
    w_next     = r_state;
    wb_cyc_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_addr_o  = 2'd0;
    wb_datw_o  = 8'h00;
    w_poll_inc = 1'b0;
    w_poll_clr = 1'b0;
    w_tx_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (int_i || r_poll == CW'(POLL_DIV-1) || r_held) w_next = ST_RD;
        else                                               w_poll_inc = 1'b1;
      end
      ST_RD: begin
        wb_cyc_o   = 1'b1;
        wb_addr_o  = 2'd1;
        w_poll_clr = 1'b1;
        w_next     = ST_CAP;
      end
      ST_CAP: begin
        if (wb_datr_i[0] && !w_full)     w_next = RX_RD;
        else if (r_held && !wb_datr_i[1]) w_next = TX_WR;
        else                              w_next = IDLE;
      end
      RX_RD: begin
        wb_cyc_o = 1'b1;
        w_next   = RX_CAP;
      end
      RX_CAP: w_next = IDLE;
      TX_WR: begin
        wb_cyc_o  = 1'b1;
        wb_we_o   = 1'b1;
        wb_datw_o = r_tx_data;
        w_tx_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        r_poll <= '0;
    else if (w_poll_clr) r_poll <= '0;
    else if (w_poll_inc) r_poll <= r_poll + CW'(1);
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_held    <= 1'b0;
      r_tx_data <= 8'h00;
    end else if (w_tx_done) begin
      r_held    <= 1'b0;
    end else if (tx_valid_i && !r_held) begin
      r_held    <= 1'b1;
      r_tx_data <= tx_data_i;
    end
  end

  // Storage needs no reset; rx_data_o is masked while empty.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wb_datr_i;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_stream_adapter.sv
// Scoreboard bench: a UART register model answers the bus, expected RX bytes and
// TX writes are queued at stimulus time and checked by a monitor at negedge.
module tb_uart_stream_adapter;
  logic       wb_clk_i = 1'b0;
  logic       rst_n_i;
  logic       wb_cyc_o, wb_we_o;
  logic [1:0] wb_addr_o;
  logic [7:0] wb_datr_i, wb_datw_o;
  logic       int_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i, tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ready_i;
  logic [3:0] rx_level_o;

  uart_stream_adapter #(.FIFO_DEPTH(8), .POLL_DIV(16)) dut (
    .wb_clk_i(wb_clk_i), .rst_n_i(rst_n_i),
    .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_datr_i(wb_datr_i), .wb_datw_o(wb_datw_o), .int_i(int_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_level_o(rx_level_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0, errors = 0;
  int cyc_n = 0, n_st = 0, n_rd = 0, n_wr = 0, rd_at_wr = 0;
  int last_st = 0, prev_st = 0, rd_cyc = 0, rxv_rise = 0, rxv_cycles = 0;
  int busy_polls = 0;
  logic       rxv_prev = 1'b0;
  logic [7:0] datr_q = 8'h00;
  logic [7:0] uart_rxq[$];
  logic [7:0] rxq[$];
  logic [9:0] txq[$];

  assign wb_datr_i = datr_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i); #1;
  endtask

  // UART register model plus output monitor; all bus and stream sampling happens here.
  task automatic monitor();
    logic [7:0] eb;
    logic [9:0] ew;
    forever begin
      @(negedge wb_clk_i);
      cyc_n++;
      if (rx_valid_o) begin
        rxv_cycles++;
        if (!rxv_prev) rxv_rise = cyc_n;
      end
      rxv_prev = rx_valid_o;
      if (rx_valid_o && rx_ready_i) begin
        if (rxq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected got %0h expected none", rx_data_o);
        end else begin
          eb = rxq.pop_front();
          check("rx_data", rx_data_o, eb);
        end
      end
      if (wb_cyc_o) begin
        if (wb_we_o) begin
          n_wr++;
          rd_at_wr = n_rd;
          if (txq.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected got %0h expected none", {wb_addr_o, wb_datw_o});
          end else begin
            ew = txq.pop_front();
            check("tx_write", {wb_addr_o, wb_datw_o}, ew);
          end
        end else if (wb_addr_o == 2'd1) begin
          n_st++;
          prev_st = last_st;
          last_st = cyc_n;
          datr_q  = {6'b0, busy_polls != 0, uart_rxq.size() != 0};
          if (busy_polls > 0) busy_polls--;
        end else begin
          n_rd++;
          rd_cyc = cyc_n;
          datr_q = (uart_rxq.size() != 0) ? uart_rxq.pop_front() : 8'hEE;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},     wb_cyc_o,   0);
    check({tag, "_we"},      wb_we_o,    0);
    check({tag, "_addr"},    wb_addr_o,  0);
    check({tag, "_datw"},    wb_datw_o,  0);
    check({tag, "_rxvalid"}, rx_valid_o, 0);
    check({tag, "_level"},   rx_level_o, 0);
    check({tag, "_rxdata"},  rx_data_o,  0);
    check({tag, "_txready"}, tx_ready_o, 1);
  endtask

  initial begin
    int n0, w0, r0, rv0;
    rst_n_i = 1'b0; int_i = 1'b0; tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
    fork monitor(); join_none
    #1;
    check_reset_outputs("reset");
    tick(); tick();

    // Interrupt-driven single RX byte, checked for sequence and latency
    rst_n_i = 1'b1; rx_ready_i = 1'b1; int_i = 1'b1;
    uart_rxq.push_back(8'h5A); rxq.push_back(8'h5A);
    rv0 = rxv_cycles;
    tick();
    int_i = 1'b0;
    repeat (10) tick();
    check("rx1_count",        rxq.size(), 0);
    check("rx1_valid_cycles", rxv_cycles - rv0, 1);
    check("rx1_rd_after_st",  rd_cyc - last_st, 2);
    check("rx1_latency",      rxv_rise - last_st, 4);

    // Unsolicited polling period with quiet status
    n0 = n_st;
    for (int k = 0; k < 100 && n_st < n0 + 2; k++) tick();
    check("poll_seen",   n_st >= n0 + 2, 1);
    check("poll_period", last_st - prev_st, 18);

    // TX write deferred by three busy polls
    repeat (3) tick();
    check("tx_ready_idle", tx_ready_o, 1);
    busy_polls = 3; tx_data_i = 8'hA5; tx_valid_i = 1'b1;
    txq.push_back({2'd0, 8'hA5});
    n0 = n_st; w0 = n_wr;
    tick();
    tx_valid_i = 1'b0;
    check("tx_ready_held", tx_ready_o, 0);
    for (int k = 0; k < 300 && n_wr == w0; k++) tick();
    check("tx_ready_after_wr", tx_ready_o, 1);
    check("tx_polls",          n_st - n0, 4);
    repeat (40) tick();
    check("tx_write_count", n_wr - w0, 1);
    check("tx_queue_empty", txq.size(), 0);

    // FIFO fill with stalled sink, then single pop re-enables reads
    rx_ready_i = 1'b0; int_i = 1'b1;
    r0 = n_rd;
    for (int b = 0; b < 10; b++) begin
      uart_rxq.push_back(8'h10 + 8'(b));
      rxq.push_back(8'h10 + 8'(b));
    end
    for (int k = 0; k < 200 && rx_level_o != 4'd8; k++) tick();
    check("full_level",  rx_level_o, 8);
    check("full_reads",  n_rd - r0, 8);
    r0 = n_rd;
    repeat (30) tick();
    check("full_no_read",   n_rd - r0, 0);
    check("full_level_hold", rx_level_o, 8);
    check("full_tx_ready",  tx_ready_o, 1);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    check("pop_level", rx_level_o, 7);
    for (int k = 0; k < 30 && n_rd == r0; k++) tick();
    check("read_resumes", n_rd - r0, 1);
    rx_ready_i = 1'b1;
    for (int k = 0; k < 300 && (rx_level_o != 0 || uart_rxq.size() != 0); k++) tick();
    repeat (6) tick();
    int_i = 1'b0;
    check("drain_rxq", rxq.size(), 0);

    // RX has priority over a held TX byte
    repeat (3) tick();
    uart_rxq.push_back(8'h77); rxq.push_back(8'h77);
    uart_rxq.push_back(8'h78); rxq.push_back(8'h78);
    busy_polls = 1;
    txq.push_back({2'd0, 8'h3C});
    tx_data_i = 8'h3C; tx_valid_i = 1'b1;
    r0 = n_rd; w0 = n_wr;
    tick();
    tx_valid_i = 1'b0;
    for (int k = 0; k < 100 && n_wr == w0; k++) tick();
    check("prio_write_seen",   n_wr - w0, 1);
    check("prio_reads_before", rd_at_wr - r0, 2);
    repeat (4) tick();
    check("prio_rxq", rxq.size(), 0);
    check("prio_txq", txq.size(), 0);

    // Reset asserted in the middle of a data read
    rx_ready_i = 1'b0; int_i = 1'b1;
    for (int b = 0; b < 4; b++) uart_rxq.push_back(8'h81 + 8'(b));
    for (int k = 0; k < 100 && rx_level_o != 4'd3; k++) tick();
    check("mid_level3", rx_level_o, 3);
    for (int k = 0; k < 20 && !(wb_cyc_o && !wb_we_o && wb_addr_o == 2'd0); k++) tick();
    check("mid_in_rxrd", wb_cyc_o && !wb_we_o && wb_addr_o == 2'd0, 1);
    #1 rst_n_i = 1'b0;
    #1 check_reset_outputs("midrst");
    uart_rxq.delete();
    int_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    tick(); tick();
    check("post_rst_level", rx_level_o, 0);
    check("post_rst_valid", rx_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
